// File: rtl/sort_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sort_pkg                                                         |
// | Purpose  : Shared types and constants for the sort stream controller.       |
// |            - ctrl_state_t : packet controller state encoding                |
// |            - RAM_RD_LAT   : cycles from RAM address to valid read data      |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package sort_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_SORT_START = 3'd2,
    ST_SORT_WAIT  = 3'd3,
    ST_READ       = 3'd4
  } ctrl_state_t;

  localparam int RAM_RD_LAT = 1;

endpackage : sort_pkg
`default_nettype wire

// File: rtl/sort_out_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sort_out_fifo                                                    |
// | Purpose  : Two-entry show-ahead FIFO feeding the sorted output stream.      |
// |            The head entry is visible on data_o whenever valid_o is high     |
// |            and only changes after it has been popped.                       |
// | Ports    : clk_i, rst_ni        - clock, async active-low reset            |
// |            push_i, data_i       - write side                               |
// |            pop_i                - consume head entry                        |
// |            data_o, valid_o      - head entry and its valid flag             |
// |            count_o              - current occupancy (0..2)                  |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module sort_out_fifo #(
  parameter int WIDTH = 12
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_cnt;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = pop_i & (r_cnt != 2'd0);
  // A full FIFO may still accept a word in the same cycle its head leaves.
  assign w_push = push_i & ((r_cnt != 2'd2) | w_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 2'd1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  assign data_o  = r_mem[r_rd_ptr];
  assign valid_o = (r_cnt != 2'd0);
  assign count_o = r_cnt;

endmodule : sort_out_fifo
`default_nettype wire

// File: rtl/sort_stream_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sort_stream_ctrl                                                 |
// | Purpose  : Packet controller around bubble_sort and its dual-port RAM.      |
// |            Loads one sink packet into RAM, kicks the sorter, then streams   |
// |            the sorted words out ascending from address 0.                   |
// | Ports    : clk_i, rst_ni              - clock, async active-low reset      |
// |            snk_*                      - input packet (valid/ready)         |
// |            src_*                      - sorted output packet (valid/ready) |
// |            sort_address/data/wren_*   - sorter RAM requests                |
// |            sort_done_i, sorting_o     - sorter handshake                   |
// |            max_counter_o              - packet length for the sorter       |
// |            ram_*                      - dual-port RAM interface            |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module sort_stream_ctrl
  import sort_pkg::*;
#(
  parameter int DWIDTH  = 10,
  parameter int ADDR_SZ = 10
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [DWIDTH-1:0]  snk_data_i,
  input  logic               snk_startofpacket_i,
  input  logic               snk_endofpacket_i,
  input  logic               snk_valid_i,
  output logic               snk_ready_o,
  output logic [DWIDTH-1:0]  src_data_o,
  output logic               src_startofpacket_o,
  output logic               src_endofpacket_o,
  output logic               src_valid_o,
  input  logic               src_ready_i,
  input  logic [ADDR_SZ-1:0] sort_address_a_i,
  input  logic [ADDR_SZ-1:0] sort_address_b_i,
  input  logic [DWIDTH-1:0]  sort_data_a_i,
  input  logic [DWIDTH-1:0]  sort_data_b_i,
  input  logic               sort_wren_a_i,
  input  logic               sort_wren_b_i,
  input  logic               sort_done_i,
  output logic               sorting_o,
  output logic [ADDR_SZ:0]   max_counter_o,
  output logic [ADDR_SZ-1:0] ram_address_a_o,
  output logic [ADDR_SZ-1:0] ram_address_b_o,
  output logic [DWIDTH-1:0]  ram_data_a_o,
  output logic [DWIDTH-1:0]  ram_data_b_o,
  output logic               ram_wren_a_o,
  output logic               ram_wren_b_o,
  input  logic [DWIDTH-1:0]  ram_q_a_i,
  input  logic [DWIDTH-1:0]  ram_q_b_i
);

  localparam logic [ADDR_SZ:0] c_cap    = {1'b1, {ADDR_SZ{1'b0}}};
  localparam logic [ADDR_SZ:0] c_one    = (ADDR_SZ+1)'(1);
  localparam logic [ADDR_SZ:0] c_two    = (ADDR_SZ+1)'(2);
  localparam int               c_fifo_w = DWIDTH + 2;

  ctrl_state_t           r_state;
  ctrl_state_t           w_state_next;
  logic [ADDR_SZ:0]      r_count;
  logic [ADDR_SZ:0]      w_count_next;
  logic                  w_snk_acc;
  logic                  w_in_cap;
  logic                  w_wr_en;
  logic [ADDR_SZ-1:0]    w_wr_addr;
  logic                  r_wait_first;
  logic [ADDR_SZ:0]      r_rd_addr;
  logic                  w_rd_issue;
  logic [RAM_RD_LAT-1:0] r_pipe_vld;
  logic [RAM_RD_LAT-1:0] r_pipe_sop;
  logic [RAM_RD_LAT-1:0] r_pipe_eop;
  logic [RAM_RD_LAT-1:0] w_pipe_vld_next;
  logic [RAM_RD_LAT-1:0] w_pipe_sop_next;
  logic [RAM_RD_LAT-1:0] w_pipe_eop_next;
  logic [2:0]            w_inflight;
  logic [2:0]            w_pending;
  logic                  w_fifo_pop;
  logic                  w_fifo_valid;
  logic [1:0]            w_fifo_cnt;
  logic [c_fifo_w-1:0]   w_fifo_din;
  logic [c_fifo_w-1:0]   w_fifo_dout;
  logic                  w_unused;

  // Port B read data goes straight to the sorter; nothing here consumes it.
  assign w_unused = ^ram_q_b_i;

  // ---------------------------------------------------------------- sink side
  // Held low while reset is asserted so no beat is taken during reset.
  assign snk_ready_o = rst_ni & ((r_state == ST_IDLE) | (r_state == ST_LOAD));
  assign w_snk_acc   = snk_valid_i & snk_ready_o;
  assign w_in_cap    = (r_count < c_cap);

  always_comb begin
    w_wr_en      = 1'b0;
    w_wr_addr    = '0;
    w_count_next = r_count;
    if (w_snk_acc) begin
      if (snk_startofpacket_i) begin
        // SOP always (re)starts the packet at address 0.
        w_wr_en      = 1'b1;
        w_count_next = c_one;
      end else if ((r_state == ST_LOAD) && w_in_cap) begin
        w_wr_en      = 1'b1;
        w_wr_addr    = r_count[ADDR_SZ-1:0];
        w_count_next = r_count + c_one;
      end
    end
  end

  // -------------------------------------------------------------------- FSM
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_snk_acc && snk_startofpacket_i)
          w_state_next = snk_endofpacket_i ? ST_READ : ST_LOAD;
      end
      ST_LOAD: begin
        if (w_snk_acc && snk_endofpacket_i)
          w_state_next = (w_count_next >= c_two) ? ST_SORT_START : ST_READ;
      end
      ST_SORT_START: w_state_next = ST_SORT_WAIT;
      ST_SORT_WAIT: begin
        // done is still high from the previous sort during the first cycle.
        if (!r_wait_first && sort_done_i) w_state_next = ST_READ;
      end
      ST_READ: begin
        if (w_fifo_pop && src_endofpacket_o) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_wait_first <= 1'b0;
      r_rd_addr    <= '0;
      r_pipe_vld   <= '0;
      r_pipe_sop   <= '0;
      r_pipe_eop   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_count      <= w_count_next;
      r_wait_first <= (r_state == ST_SORT_START);
      if (r_state != ST_READ) r_rd_addr <= '0;
      else if (w_rd_issue)    r_rd_addr <= r_rd_addr + c_one;
      r_pipe_vld   <= w_pipe_vld_next;
      r_pipe_sop   <= w_pipe_sop_next;
      r_pipe_eop   <= w_pipe_eop_next;
    end
  end

  assign sorting_o     = (r_state == ST_SORT_START);
  assign max_counter_o = ((r_state == ST_IDLE) || (r_state == ST_LOAD)) ? '0 : r_count;

  // ------------------------------------------------------------ read engine
  // Read tags travel alongside the RAM latency so SOP/EOP land on the
  // matching data word.
  if (RAM_RD_LAT == 1) begin : g_rd_pipe_single
    assign w_pipe_vld_next = w_rd_issue;
    assign w_pipe_sop_next = (r_rd_addr == '0);
    assign w_pipe_eop_next = (r_rd_addr == (r_count - c_one));
  end else begin : g_rd_pipe_multi
    assign w_pipe_vld_next = {r_pipe_vld[RAM_RD_LAT-2:0], w_rd_issue};
    assign w_pipe_sop_next = {r_pipe_sop[RAM_RD_LAT-2:0], (r_rd_addr == '0)};
    assign w_pipe_eop_next = {r_pipe_eop[RAM_RD_LAT-2:0], (r_rd_addr == (r_count - c_one))};
  end

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RAM_RD_LAT; i++) w_inflight = w_inflight + 3'(r_pipe_vld[i]);
  end

  // Counting the word leaving this cycle keeps the output at one word/cycle.
  assign w_pending  = {1'b0, w_fifo_cnt} + w_inflight - 3'(w_fifo_pop);
  assign w_rd_issue = (r_state == ST_READ) && (r_rd_addr < r_count) && (w_pending < 3'd2);

  assign w_fifo_din = {ram_q_a_i, r_pipe_sop[RAM_RD_LAT-1], r_pipe_eop[RAM_RD_LAT-1]};
  assign w_fifo_pop = w_fifo_valid & src_ready_i;

  sort_out_fifo #(
    .WIDTH (c_fifo_w)
  ) u_out_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (r_pipe_vld[RAM_RD_LAT-1]),
    .data_i  (w_fifo_din),
    .pop_i   (w_fifo_pop),
    .data_o  (w_fifo_dout),
    .valid_o (w_fifo_valid),
    .count_o (w_fifo_cnt)
  );

  assign {src_data_o, src_startofpacket_o, src_endofpacket_o} = w_fifo_dout;
  assign src_valid_o = w_fifo_valid;

  // ---------------------------------------------------------------- RAM mux
  always_comb begin
    ram_address_a_o = '0;
    ram_address_b_o = '0;
    ram_data_a_o    = '0;
    ram_data_b_o    = '0;
    ram_wren_a_o    = 1'b0;
    ram_wren_b_o    = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_LOAD: begin
        ram_address_a_o = w_wr_addr;
        ram_data_a_o    = snk_data_i;
        ram_wren_a_o    = w_wr_en;
      end
      ST_SORT_WAIT: begin
        ram_address_a_o = sort_address_a_i;
        ram_address_b_o = sort_address_b_i;
        ram_data_a_o    = sort_data_a_i;
        ram_data_b_o    = sort_data_b_i;
        ram_wren_a_o    = sort_wren_a_i;
        ram_wren_b_o    = sort_wren_b_i;
      end
      ST_READ: begin
        ram_address_a_o = r_rd_addr[ADDR_SZ-1:0];
      end
      default: ;
    endcase
  end

endmodule : sort_stream_ctrl
`default_nettype wire

// File: tb/tb_sort_stream_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sort_stream_ctrl                                              |
// | Purpose  : Directed self-checking bench for sort_stream_ctrl with a         |
// |            behavioural dual-port RAM and a sorter stand-in that writes the  |
// |            sorted words back through the sort_* ports.                      |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_sort_stream_ctrl;

  localparam int DWIDTH  = 10;
  localparam int ADDR_SZ = 10;
  localparam int CAP     = 1 << ADDR_SZ;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic [DWIDTH-1:0]  snk_data_i;
  logic               snk_startofpacket_i, snk_endofpacket_i, snk_valid_i, snk_ready_o;
  logic [DWIDTH-1:0]  src_data_o;
  logic               src_startofpacket_o, src_endofpacket_o, src_valid_o, src_ready_i;
  logic [ADDR_SZ-1:0] sort_address_a_i, sort_address_b_i;
  logic [DWIDTH-1:0]  sort_data_a_i, sort_data_b_i;
  logic               sort_wren_a_i, sort_wren_b_i, sort_done_i, sorting_o;
  logic [ADDR_SZ:0]   max_counter_o;
  logic [ADDR_SZ-1:0] ram_address_a_o, ram_address_b_o;
  logic [DWIDTH-1:0]  ram_data_a_o, ram_data_b_o;
  logic               ram_wren_a_o, ram_wren_b_o;
  logic [DWIDTH-1:0]  ram_q_a_i, ram_q_b_i;

  logic [DWIDTH-1:0]  mem [CAP];
  int n_tests = 0;
  int n_fail  = 0;
  int sort_pulses = 0;

  always #5 clk_i = ~clk_i;

  sort_stream_ctrl #(.DWIDTH(DWIDTH), .ADDR_SZ(ADDR_SZ)) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .snk_data_i          (snk_data_i),
    .snk_startofpacket_i (snk_startofpacket_i),
    .snk_endofpacket_i   (snk_endofpacket_i),
    .snk_valid_i         (snk_valid_i),
    .snk_ready_o         (snk_ready_o),
    .src_data_o          (src_data_o),
    .src_startofpacket_o (src_startofpacket_o),
    .src_endofpacket_o   (src_endofpacket_o),
    .src_valid_o         (src_valid_o),
    .src_ready_i         (src_ready_i),
    .sort_address_a_i    (sort_address_a_i),
    .sort_address_b_i    (sort_address_b_i),
    .sort_data_a_i       (sort_data_a_i),
    .sort_data_b_i       (sort_data_b_i),
    .sort_wren_a_i       (sort_wren_a_i),
    .sort_wren_b_i       (sort_wren_b_i),
    .sort_done_i         (sort_done_i),
    .sorting_o           (sorting_o),
    .max_counter_o       (max_counter_o),
    .ram_address_a_o     (ram_address_a_o),
    .ram_address_b_o     (ram_address_b_o),
    .ram_data_a_o        (ram_data_a_o),
    .ram_data_b_o        (ram_data_b_o),
    .ram_wren_a_o        (ram_wren_a_o),
    .ram_wren_b_o        (ram_wren_b_o),
    .ram_q_a_i           (ram_q_a_i),
    .ram_q_b_i           (ram_q_b_i)
  );

  // Dual-port RAM, one cycle read latency, read-before-write.
  always @(posedge clk_i) begin
    if (ram_wren_a_o) mem[ram_address_a_o] <= ram_data_a_o;
    if (ram_wren_b_o) mem[ram_address_b_o] <= ram_data_b_o;
    ram_q_a_i <= mem[ram_address_a_o];
    ram_q_b_i <= mem[ram_address_b_o];
    if (sorting_o) sort_pulses <= sort_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_packet(input int vals[$]);
    for (int i = 0; i < vals.size(); i++) begin
      int g;
      g = 0;
      @(negedge clk_i);
      snk_valid_i         = 1'b1;
      snk_data_i          = DWIDTH'(vals[i]);
      snk_startofpacket_i = (i == 0);
      snk_endofpacket_i   = (i == vals.size() - 1);
      while (!snk_ready_o && g < 20) begin
        @(negedge clk_i);
        g++;
      end
      if (!snk_ready_o) check("snk_ready_o timeout", 32'd0, 32'd1);
    end
    @(negedge clk_i);
    snk_valid_i         = 1'b0;
    snk_startofpacket_i = 1'b0;
    snk_endofpacket_i   = 1'b0;
  endtask

  // Called in the cycle sorting_o should be high. Leaves done=1 stale for
  // the first wait cycle, then writes the sorted words through ports A/B.
  task automatic do_sort(input int n);
    int arr[$];
    check("sorting_o asserted", 32'(sorting_o), 32'd1);
    check("max_counter_o", 32'(max_counter_o), n);
    for (int i = 0; i < n; i++) arr.push_back(int'(mem[i]));
    arr.sort();
    @(negedge clk_i);
    check("sorting_o one cycle", 32'(sorting_o), 32'd0);
    check("snk_ready_o low in sort", 32'(snk_ready_o), 32'd0);
    @(negedge clk_i);
    sort_done_i = 1'b0;
    for (int i = 0; i < n; i += 2) begin
      sort_address_a_i = ADDR_SZ'(i);
      sort_data_a_i    = DWIDTH'(arr[i]);
      sort_wren_a_i    = 1'b1;
      if (i + 1 < n) begin
        sort_address_b_i = ADDR_SZ'(i + 1);
        sort_data_b_i    = DWIDTH'(arr[i + 1]);
        sort_wren_b_i    = 1'b1;
      end else begin
        sort_wren_b_i    = 1'b0;
      end
      @(negedge clk_i);
    end
    sort_wren_a_i = 1'b0;
    sort_wren_b_i = 1'b0;
    sort_done_i   = 1'b1;
  endtask

  task automatic read_packet(input int exp[$], input bit rand_ready,
                             output int first_lat, output int span);
    int k, cyc, first_acc, last_acc;
    bit held;
    logic [DWIDTH+1:0] held_v;
    k = 0; cyc = 0; first_acc = -1; last_acc = -1; held = 1'b0; held_v = '0;
    first_lat = -1;
    while (k < exp.size() && cyc < 20 * exp.size() + 100) begin
      @(negedge clk_i);
      cyc++;
      src_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (held)
        check("hold stable", {31'd0, src_valid_o} << 12 | 32'({src_data_o, src_startofpacket_o, src_endofpacket_o}),
              32'h1000 | 32'(held_v));
      if (src_valid_o && first_lat < 0) first_lat = cyc;
      if (src_valid_o && src_ready_i) begin
        check($sformatf("data[%0d]", k), 32'(src_data_o), exp[k]);
        check($sformatf("sop[%0d]", k), 32'(src_startofpacket_o), 32'(k == 0));
        check($sformatf("eop[%0d]", k), 32'(src_endofpacket_o), 32'(k == exp.size() - 1));
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        k++;
        held = 1'b0;
      end else if (src_valid_o) begin
        held   = 1'b1;
        held_v = {src_data_o, src_startofpacket_o, src_endofpacket_o};
      end else begin
        held = 1'b0;
      end
    end
    if (k < exp.size()) check("read timeout words", k, exp.size());
    @(negedge clk_i);
    src_ready_i = 1'b0;
    check("src_valid_o low after packet", 32'(src_valid_o), 32'd0);
    check("snk_ready_o back in idle", 32'(snk_ready_o), 32'd1);
    span = last_acc - first_acc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int vals[$];
    int exp[$];
    int lat, span, p0, g;

    rst_ni = 1'b0;
    snk_data_i = '0; snk_startofpacket_i = 1'b0; snk_endofpacket_i = 1'b0; snk_valid_i = 1'b0;
    src_ready_i = 1'b0;
    sort_address_a_i = '0; sort_address_b_i = '0; sort_data_a_i = '0; sort_data_b_i = '0;
    sort_wren_a_i = 1'b0; sort_wren_b_i = 1'b0;
    sort_done_i = 1'b1;  // stale done from a previous sort

    #1;
    check("reset snk_ready_o", 32'(snk_ready_o), 32'd0);
    check("reset src_valid_o", 32'(src_valid_o), 32'd0);
    check("reset sorting_o", 32'(sorting_o), 32'd0);
    check("reset max_counter_o", 32'(max_counter_o), 32'd0);
    check("reset ram_wren_a_o", 32'(ram_wren_a_o), 32'd0);
    check("reset ram_wren_b_o", 32'(ram_wren_b_o), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    #1 check("idle snk_ready_o", 32'(snk_ready_o), 32'd1);

    // Beat without SOP in IDLE: accepted but never written.
    @(negedge clk_i);
    snk_valid_i = 1'b1; snk_data_i = 10'd555; snk_startofpacket_i = 1'b0; snk_endofpacket_i = 1'b1;
    #1 check("stray beat ram_wren_a_o", 32'(ram_wren_a_o), 32'd0);
    @(negedge clk_i);
    snk_valid_i = 1'b0; snk_endofpacket_i = 1'b0;
    check("stray beat stays idle", 32'(snk_ready_o), 32'd1);

    // 5-word packet
    p0 = sort_pulses;
    vals = '{7, 3, 9, 1, 3};
    send_packet(vals);
    do_sort(5);
    exp = '{1, 3, 3, 7, 9};
    read_packet(exp, 1'b0, lat, span);
    check("t5 first valid latency", lat, 3);
    check("t5 back-to-back span", span, 4);
    check("t5 sorting pulses", sort_pulses - p0, 1);

    // 1-word packet: no sort
    p0 = sort_pulses;
    vals = '{42};
    send_packet(vals);
    check("t1 sorting_o stays low", 32'(sorting_o), 32'd0);
    exp = '{42};
    read_packet(exp, 1'b0, lat, span);
    check("t1 first valid latency", lat, 2);
    check("t1 sorting pulses", sort_pulses - p0, 0);

    // 2-word packet with stale done
    vals = '{5, 2};
    send_packet(vals);
    do_sort(2);
    exp = '{2, 5};
    read_packet(exp, 1'b0, lat, span);

    // 16 words, random backpressure
    vals.delete();
    for (int i = 0; i < 16; i++) vals.push_back((i * 37 + 11) % 100);
    exp = vals;
    exp.sort();
    send_packet(vals);
    do_sort(16);
    read_packet(exp, 1'b1, lat, span);

    // Over-capacity packet
    vals.delete();
    exp.delete();
    for (int i = 0; i < CAP + 3; i++) vals.push_back((i * 389 + 5) % 1024);
    for (int i = 0; i < CAP; i++) exp.push_back(vals[i]);
    exp.sort();
    send_packet(vals);
    do_sort(CAP);
    read_packet(exp, 1'b0, lat, span);
    check("cap back-to-back span", span, CAP - 1);

    // Reset in the middle of READ
    vals = '{8, 6, 4, 2};
    send_packet(vals);
    do_sort(4);
    src_ready_i = 1'b0;
    g = 0;
    while (!src_valid_o && g < 20) begin
      @(negedge clk_i);
      g++;
    end
    check("rst pre src_valid_o", 32'(src_valid_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("rst mid src_valid_o", 32'(src_valid_o), 32'd0);
    check("rst mid snk_ready_o", 32'(snk_ready_o), 32'd0);
    check("rst mid sorting_o", 32'(sorting_o), 32'd0);
    check("rst mid max_counter_o", 32'(max_counter_o), 32'd0);
    check("rst mid ram_wren_a_o", 32'(ram_wren_a_o), 32'd0);
    check("rst mid ram_wren_b_o", 32'(ram_wren_b_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    vals = '{4, 1};
    send_packet(vals);
    do_sort(2);
    exp = '{1, 4};
    read_packet(exp, 1'b0, lat, span);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_sort_stream_ctrl
`default_nettype wire
